// File: rtl/mp3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mp3_pkg
// Brief    : Parser state codes, MPEG-1 Layer III header field positions and
//            the frame-length table shared by the parser and later stages.
// Revision : 1.0
// ============================================================================
package mp3_pkg;

  localparam int FLEN_W_DEF = 11;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_H1      = 3'd1;
  localparam logic [2:0] ST_H2      = 3'd2;
  localparam logic [2:0] ST_H3      = 3'd3;
  localparam logic [2:0] ST_CRC0    = 3'd4;
  localparam logic [2:0] ST_CRC1    = 3'd5;
  localparam logic [2:0] ST_PAYLOAD = 3'd6;

  localparam logic [7:0] SYNC_BYTE   = 8'hFF;
  // Byte 1 bits [7:1]: sync tail 111, version 11 (MPEG-1), layer 01 (Layer III)
  localparam logic [6:0] MPEG1_L3_ID = 7'b1111101;
  localparam logic [3:0] BR_FREE     = 4'd0;
  localparam logic [3:0] BR_BAD      = 4'd15;
  localparam logic [1:0] SR_RESERVED = 2'd3;

  localparam int HDR_PROT_BIT = 0;
  localparam int HDR_BR_MSB   = 7;
  localparam int HDR_BR_LSB   = 4;
  localparam int HDR_SR_MSB   = 3;
  localparam int HDR_SR_LSB   = 2;
  localparam int HDR_PAD_BIT  = 1;
  localparam int HDR_CM_MSB   = 7;
  localparam int HDR_CM_LSB   = 6;
  localparam int HDR_ME_MSB   = 5;
  localparam int HDR_ME_LSB   = 4;

  // floor(144000 * kbps / fs) for 44.1 kHz, 48 kHz, 32 kHz; index 0 (free format) unused
  localparam logic [10:0] FLEN_LUT [3][15] = '{
    '{11'd0, 11'd104, 11'd130, 11'd156, 11'd182, 11'd208, 11'd261, 11'd313,
      11'd365, 11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044},
    '{11'd0, 11'd96, 11'd120, 11'd144, 11'd168, 11'd192, 11'd240, 11'd288,
      11'd336, 11'd384, 11'd480, 11'd576, 11'd672, 11'd768, 11'd960},
    '{11'd0, 11'd144, 11'd180, 11'd216, 11'd252, 11'd288, 11'd360, 11'd432,
      11'd504, 11'd576, 11'd720, 11'd864, 11'd1008, 11'd1152, 11'd1440}
  };

  function automatic logic is_mpeg1_l3(input logic [7:0] b);
    return b[7:1] == MPEG1_L3_ID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp3_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : mp3_frame_parser_if
// Brief    : Byte stream in, payload stream and decoded header fields out.
//            MP3_SYNC_LOCK_EN adds the sync_errs counter.
// Revision : 1.0
// ============================================================================
interface mp3_frame_parser_if #(parameter int FLEN_W = 11);
  logic [7:0]        axiid;
  logic              axiiv;
  logic [7:0]        axiod;
  logic              axiov;
  logic              axio_last;
  logic              hdr_valid;
  logic [3:0]        bitrate_idx;
  logic [1:0]        sr_idx;
  logic              padding;
  logic              crc_present;
  logic [1:0]        ch_mode;
  logic [1:0]        mode_ext;
  logic [FLEN_W-1:0] frame_len;
  logic              in_sync;
`ifdef MP3_SYNC_LOCK_EN
  logic [15:0]       sync_errs;
`endif

  modport master (
    input  axiid, axiiv,
    output axiod, axiov, axio_last, hdr_valid, bitrate_idx, sr_idx, padding,
           crc_present, ch_mode, mode_ext, frame_len, in_sync
`ifdef MP3_SYNC_LOCK_EN
    , output sync_errs
`endif
  );

  modport slave (
    output axiid, axiiv,
    input  axiod, axiov, axio_last, hdr_valid, bitrate_idx, sr_idx, padding,
           crc_present, ch_mode, mode_ext, frame_len, in_sync
`ifdef MP3_SYNC_LOCK_EN
    , input sync_errs
`endif
  );
endinterface
`default_nettype wire

// File: rtl/mp3_flen_lut.sv
`default_nettype none
// ============================================================================
// Module   : mp3_flen_lut
// Brief    : Combinational frame length in bytes from header indices.
// Revision : 1.0
// ============================================================================
module mp3_flen_lut
  import mp3_pkg::*;
#(
  parameter int FLEN_W = FLEN_W_DEF
) (
  input  logic [1:0]        sr_idx,
  input  logic [3:0]        bitrate_idx,
  input  logic              padding,
  output logic [FLEN_W-1:0] frame_len
);
  logic [10:0] base_len;

  always_comb begin
    base_len = '0;
    if (sr_idx != SR_RESERVED && bitrate_idx != BR_BAD)
      base_len = FLEN_LUT[sr_idx][bitrate_idx];
    frame_len = FLEN_W'(base_len) + FLEN_W'(padding);
  end
endmodule
`default_nettype wire

// File: rtl/mp3_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : mp3_frame_parser
// Brief    : MPEG-1 Layer III sync hunt, header decode, CRC skip and payload
//            forwarding. Optional MP3_SYNC_LOCK_EN locks the sample rate.
// Revision : 1.0
// ============================================================================
module mp3_frame_parser
  import mp3_pkg::*;
#(
  parameter int FLEN_W = FLEN_W_DEF
) (
  input logic                clk,
  input logic                rst,
  mp3_frame_parser_if.master bus
);
  logic [2:0]        state_q, state_d;
  logic [3:0]        br_tmp_q, br_tmp_d;
  logic [1:0]        sr_tmp_q, sr_tmp_d;
  logic              pad_tmp_q, pad_tmp_d, crc_tmp_q, crc_tmp_d;
  logic [FLEN_W-1:0] cnt_q, cnt_d, frame_len_q, frame_len_d, flen_w;
  logic [7:0]        axiod_q, axiod_d;
  logic              axiov_q, axiov_d, last_q, last_d, hdr_valid_q, hdr_valid_d;
  logic [3:0]        bitrate_idx_q, bitrate_idx_d;
  logic [1:0]        sr_idx_q, sr_idx_d, ch_mode_q, ch_mode_d, mode_ext_q, mode_ext_d;
  logic              padding_q, padding_d, crc_present_q, crc_present_d;
  logic              in_sync_q, in_sync_d;
  logic              hdr_reject, hdr_bad;
  logic [7:0]        b;
`ifdef MP3_SYNC_LOCK_EN
  logic              lock_valid_q, lock_valid_d;
  logic [1:0]        lock_sr_q, lock_sr_d;
  logic [15:0]       sync_errs_q, sync_errs_d;
`endif

  assign b = bus.axiid;

  mp3_flen_lut #(.FLEN_W(FLEN_W)) u_flen_lut (
    .sr_idx      (sr_tmp_q),
    .bitrate_idx (br_tmp_q),
    .padding     (pad_tmp_q),
    .frame_len   (flen_w)
  );

  always_comb begin
    state_d       = state_q;
    br_tmp_d      = br_tmp_q;
    sr_tmp_d      = sr_tmp_q;
    pad_tmp_d     = pad_tmp_q;
    crc_tmp_d     = crc_tmp_q;
    cnt_d         = cnt_q;
    axiod_d       = axiod_q;
    axiov_d       = 1'b0;
    last_d        = 1'b0;
    hdr_valid_d   = 1'b0;
    bitrate_idx_d = bitrate_idx_q;
    sr_idx_d      = sr_idx_q;
    padding_d     = padding_q;
    crc_present_d = crc_present_q;
    ch_mode_d     = ch_mode_q;
    mode_ext_d    = mode_ext_q;
    frame_len_d   = frame_len_q;
    in_sync_d     = last_q ? 1'b0 : in_sync_q;
    hdr_reject    = 1'b0;
    hdr_bad       = (b[HDR_BR_MSB:HDR_BR_LSB] == BR_FREE) || (b[HDR_BR_MSB:HDR_BR_LSB] == BR_BAD)
                 || (b[HDR_SR_MSB:HDR_SR_LSB] == SR_RESERVED);
`ifdef MP3_SYNC_LOCK_EN
    lock_valid_d  = lock_valid_q;
    lock_sr_d     = lock_sr_q;
    hdr_bad       = hdr_bad || (lock_valid_q && (b[HDR_SR_MSB:HDR_SR_LSB] != lock_sr_q));
`endif

    if (bus.axiiv) begin
      case (state_q)
        ST_HUNT: if (b == SYNC_BYTE) state_d = ST_H1;
        ST_H1: begin
          if (is_mpeg1_l3(b)) begin
            crc_tmp_d = ~b[HDR_PROT_BIT];
            state_d   = ST_H2;
          end else begin
            hdr_reject = 1'b1;
            state_d    = (b == SYNC_BYTE) ? ST_H1 : ST_HUNT;
          end
        end
        ST_H2: begin
          if (hdr_bad) begin
            hdr_reject = 1'b1;
            state_d    = (b == SYNC_BYTE) ? ST_H1 : ST_HUNT;
          end else begin
            br_tmp_d  = b[HDR_BR_MSB:HDR_BR_LSB];
            sr_tmp_d  = b[HDR_SR_MSB:HDR_SR_LSB];
            pad_tmp_d = b[HDR_PAD_BIT];
            state_d   = ST_H3;
          end
        end
        ST_H3: begin
          hdr_valid_d   = 1'b1;
          in_sync_d     = 1'b1;
          bitrate_idx_d = br_tmp_q;
          sr_idx_d      = sr_tmp_q;
          padding_d     = pad_tmp_q;
          crc_present_d = crc_tmp_q;
          ch_mode_d     = b[HDR_CM_MSB:HDR_CM_LSB];
          mode_ext_d    = b[HDR_ME_MSB:HDR_ME_LSB];
          frame_len_d   = flen_w;
          cnt_d         = flen_w - FLEN_W'(4) - (crc_tmp_q ? FLEN_W'(2) : FLEN_W'(0));
          state_d       = crc_tmp_q ? ST_CRC0 : ST_PAYLOAD;
`ifdef MP3_SYNC_LOCK_EN
          lock_valid_d  = 1'b1;
          if (!lock_valid_q) lock_sr_d = sr_tmp_q;
`endif
        end
        ST_CRC0: state_d = ST_CRC1;
        ST_CRC1: state_d = ST_PAYLOAD;
        ST_PAYLOAD: begin
          axiod_d = b;
          axiov_d = 1'b1;
          cnt_d   = cnt_q - FLEN_W'(1);
          if (cnt_q == FLEN_W'(1)) begin
            last_d  = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

`ifdef MP3_SYNC_LOCK_EN
    sync_errs_d = sync_errs_q;
    if (hdr_reject && sync_errs_q != 16'hFFFF) sync_errs_d = sync_errs_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HUNT;
      br_tmp_q      <= '0;
      sr_tmp_q      <= '0;
      pad_tmp_q     <= 1'b0;
      crc_tmp_q     <= 1'b0;
      cnt_q         <= '0;
      axiod_q       <= '0;
      axiov_q       <= 1'b0;
      last_q        <= 1'b0;
      hdr_valid_q   <= 1'b0;
      bitrate_idx_q <= '0;
      sr_idx_q      <= '0;
      padding_q     <= 1'b0;
      crc_present_q <= 1'b0;
      ch_mode_q     <= '0;
      mode_ext_q    <= '0;
      frame_len_q   <= '0;
      in_sync_q     <= 1'b0;
`ifdef MP3_SYNC_LOCK_EN
      lock_valid_q  <= 1'b0;
      lock_sr_q     <= '0;
      sync_errs_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      br_tmp_q      <= br_tmp_d;
      sr_tmp_q      <= sr_tmp_d;
      pad_tmp_q     <= pad_tmp_d;
      crc_tmp_q     <= crc_tmp_d;
      cnt_q         <= cnt_d;
      axiod_q       <= axiod_d;
      axiov_q       <= axiov_d;
      last_q        <= last_d;
      hdr_valid_q   <= hdr_valid_d;
      bitrate_idx_q <= bitrate_idx_d;
      sr_idx_q      <= sr_idx_d;
      padding_q     <= padding_d;
      crc_present_q <= crc_present_d;
      ch_mode_q     <= ch_mode_d;
      mode_ext_q    <= mode_ext_d;
      frame_len_q   <= frame_len_d;
      in_sync_q     <= in_sync_d;
`ifdef MP3_SYNC_LOCK_EN
      lock_valid_q  <= lock_valid_d;
      lock_sr_q     <= lock_sr_d;
      sync_errs_q   <= sync_errs_d;
`endif
    end
  end

  assign bus.axiod       = axiod_q;
  assign bus.axiov       = axiov_q;
  assign bus.axio_last   = last_q;
  assign bus.hdr_valid   = hdr_valid_q;
  assign bus.bitrate_idx = bitrate_idx_q;
  assign bus.sr_idx      = sr_idx_q;
  assign bus.padding     = padding_q;
  assign bus.crc_present = crc_present_q;
  assign bus.ch_mode     = ch_mode_q;
  assign bus.mode_ext    = mode_ext_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.in_sync     = in_sync_q;
`ifdef MP3_SYNC_LOCK_EN
  assign bus.sync_errs   = sync_errs_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mp3_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp3_frame_parser
// Brief    : Directed frames against a header/payload model kept as queues.
//            Honours MP3_SYNC_LOCK_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_mp3_frame_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mp3_frame_parser_if #(.FLEN_W(11)) bus ();
  mp3_frame_parser #(.FLEN_W(11)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] br;
    logic [1:0] sr;
    logic       pad;
    logic       crc;
    logic [1:0] cm;
    logic [1:0] me;
    int         flen;
  } hdr_t;

  localparam int KBPS [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
  localparam int FS_HZ [3] = '{44100, 48000, 32000};

  int   errors = 0;
  int   checks = 0;
  hdr_t exp_hdr[$];
  logic [8:0] exp_pay[$];
  int   hdr_cnt, pay_cnt, last_cnt, seen_flen;
  bit   drop_pending = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic hdr_t decode(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    hdr_t h;
    h.br   = b2[7:4];
    h.sr   = b2[3:2];
    h.pad  = b2[1];
    h.crc  = ~b1[0];
    h.cm   = b3[7:6];
    h.me   = b3[5:4];
    h.flen = (h.sr == 2'd3) ? 0 : (144000 * KBPS[h.br]) / FS_HZ[h.sr] + int'(h.pad);
    return h;
  endfunction

  // Compare process: every header pulse and payload byte against the model queues
  always @(negedge clk) begin
    if (rst) begin
      if (drop_pending) begin
        chk("in_sync_drop", bus.in_sync, 0);
        drop_pending = 1'b0;
      end
      if (bus.hdr_valid) begin
        hdr_cnt++;
        seen_flen = int'(bus.frame_len);
        if (exp_hdr.size() == 0) chk("unexpected_hdr", 1, 0);
        else begin
          hdr_t e;
          e = exp_hdr.pop_front();
          chk("hdr_br", bus.bitrate_idx, e.br);
          chk("hdr_sr", bus.sr_idx, e.sr);
          chk("hdr_pad", bus.padding, e.pad);
          chk("hdr_crc", bus.crc_present, e.crc);
          chk("hdr_cm", bus.ch_mode, e.cm);
          chk("hdr_me", bus.mode_ext, e.me);
          chk("hdr_flen", bus.frame_len, e.flen);
          chk("hdr_in_sync", bus.in_sync, 1);
        end
      end
      if (bus.axiov) begin
        pay_cnt++;
        chk("pay_in_sync", bus.in_sync, 1);
        if (exp_pay.size() == 0) chk("unexpected_axiov", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_pay.pop_front();
          chk("pay_data", bus.axiod, e[7:0]);
          chk("pay_last", bus.axio_last, e[8]);
        end
        if (bus.axio_last) begin
          last_cnt++;
          drop_pending = 1'b1;
        end
      end else if (bus.axio_last) chk("last_without_valid", 1, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap_pct);
    while ($urandom_range(0, 99) < gap_pct) idle(1);
    bus.axiid = b;
    bus.axiiv = 1'b1;
    @(posedge clk);
    #1;
    bus.axiiv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input bit ok, input int gap_pct);
    hdr_t h;
    int   n;
    logic [7:0] d;
    h = decode(b1, b2, b3);
    if (ok) exp_hdr.push_back(h);
    send(8'hFF, gap_pct);
    send(b1, gap_pct);
    send(b2, gap_pct);
    send(b3, gap_pct);
    if (ok) begin
      if (h.crc) begin
        send(8'hA5, gap_pct);
        send(8'h5A, gap_pct);
      end
      n = h.flen - 4 - (h.crc ? 2 : 0);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 254));
        exp_pay.push_back({(i == n - 1), d});
        send(d, gap_pct);
      end
    end
  endtask

  task automatic clear_counts();
    hdr_cnt = 0; pay_cnt = 0; last_cnt = 0; seen_flen = -1;
  endtask

  task automatic chk_drained(input string tag);
    idle(4);
    chk({tag, "_hdr_q_empty"}, exp_hdr.size(), 0);
    chk({tag, "_pay_q_empty"}, exp_pay.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_axiov"}, bus.axiov, 0);
    chk({tag, "_last"}, bus.axio_last, 0);
    chk({tag, "_hdr_valid"}, bus.hdr_valid, 0);
    chk({tag, "_in_sync"}, bus.in_sync, 0);
    chk({tag, "_frame_len"}, bus.frame_len, 0);
    chk({tag, "_axiod"}, bus.axiod, 0);
    chk({tag, "_fields"}, {bus.bitrate_idx, bus.sr_idx, bus.padding, bus.crc_present,
                           bus.ch_mode, bus.mode_ext}, 0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int errs0;
    errs0 = 0;
    bus.axiid = 8'h00;
    bus.axiiv = 1'b0;
    clear_counts();
    #2 rst = 1'b0;
    #1 chk_outputs_zero("reset");
    idle(3);
    #2 rst = 1'b1;
    idle(2);

    // 1: 44.1k/128k, no pad, no CRC
    clear_counts();
    send_frame(8'hFB, 8'h90, 8'h40, 1'b1, 0);
    chk_drained("t1");
    chk("t1_flen", seen_flen, 417);
    chk("t1_hdr_cnt", hdr_cnt, 1);
    chk("t1_pay_cnt", pay_cnt, 413);
    chk("t1_last_cnt", last_cnt, 1);

    // 2: CRC present, padded
    clear_counts();
    send_frame(8'hFA, 8'h92, 8'h00, 1'b1, 0);
    chk_drained("t2");
    chk("t2_flen", seen_flen, 418);
    chk("t2_crc", bus.crc_present, 1);
    chk("t2_pay_cnt", pay_cnt, 412);

    // 3: false sync then resync on FF FF FB
    clear_counts();
`ifdef MP3_SYNC_LOCK_EN
    errs0 = int'(bus.sync_errs);
`endif
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'h12, 0);
    send(8'hFF, 0);
`ifdef MP3_SYNC_LOCK_EN
    send_frame(8'hFB, 8'h94, 8'h40, 1'b0, 0);
    chk_drained("t3");
    chk("t3_hdr_cnt", hdr_cnt, 0);
    chk("t3_sync_errs", bus.sync_errs, errs0 + 3);
`else
    send_frame(8'hFB, 8'h94, 8'h40, 1'b1, 0);
    chk_drained("t3");
    chk("t3_hdr_cnt", hdr_cnt, 1);
    chk("t3_flen", seen_flen, 384);
    chk("t3_pay_cnt", pay_cnt, 380);
`endif

    // 4: bitrate index 15 rejected
    clear_counts();
`ifdef MP3_SYNC_LOCK_EN
    errs0 = int'(bus.sync_errs);
`endif
    send_frame(8'hFB, 8'hF0, 8'h00, 1'b0, 0);
    chk_drained("t4");
    chk("t4_hdr_cnt", hdr_cnt, 0);
    chk("t4_pay_cnt", pay_cnt, 0);
    chk("t4_in_sync", bus.in_sync, 0);
`ifdef MP3_SYNC_LOCK_EN
    chk("t4_sync_errs", bus.sync_errs, errs0 + 1);
`endif

    // 5: random input gaps
    clear_counts();
    send_frame(8'hFB, 8'h90, 8'h40, 1'b1, 30);
    chk_drained("t5");
    chk("t5_pay_cnt", pay_cnt, 413);
    chk("t5_last_cnt", last_cnt, 1);

    // 6: reset at payload byte 100, then a clean frame
    clear_counts();
    begin
      hdr_t h;
      logic [7:0] d;
      h = decode(8'hFB, 8'h90, 8'h40);
      exp_hdr.push_back(h);
      send(8'hFF, 0); send(8'hFB, 0); send(8'h90, 0); send(8'h40, 0);
      for (int i = 0; i < 100; i++) begin
        d = 8'($urandom_range(0, 254));
        exp_pay.push_back({1'b0, d});
        send(d, 0);
      end
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_outputs_zero("midreset");
`ifdef MP3_SYNC_LOCK_EN
    chk("midreset_sync_errs", bus.sync_errs, 0);
`endif
    chk("t6_pay_before_reset", pay_cnt, 100);
    chk("t6_no_last", last_cnt, 0);
    idle(3);
    #2 rst = 1'b1;
    idle(1);
    chk_drained("t6a");
    clear_counts();
    send_frame(8'hFB, 8'h94, 8'h40, 1'b1, 0);
    chk_drained("t6b");
    chk("t6_flen", seen_flen, 384);
    chk("t6_pay_cnt", pay_cnt, 380);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
